// File: rtl/ahblite_vga_wbuf_pkg.sv
// ahblite_vga_wbuf_pkg: shared SoC bus constants, register map and data-phase record
package ahblite_vga_wbuf_pkg;
  localparam int REG_SEL_BIT = 15;
  localparam logic [15:0] STATUS_OFS = 16'h8000;
  localparam logic [15:0] CTRL_OFS = 16'h8004;
  localparam int STATUS_LEVEL_W = 9;
  localparam int STATUS_EMPTY_BIT = 16;
  localparam int STATUS_FULL_BIT = 17;
  localparam int STATUS_EN_BIT = 18;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  typedef struct packed {
    logic valid;
    logic write;
    logic [15:0] addr;
  } dphase_t;
  function automatic logic reg_hit(input logic [15:0] addr, input logic [15:0] ofs);
    return addr[15:2] == ofs[15:2];
  endfunction
endpackage

// File: rtl/ahblite_vga_wbuf_if.sv
// ahblite_vga_wbuf_if: AHB-Lite slave-port bundle
interface ahblite_vga_wbuf_if;
  logic HSEL;
  logic [31:0] HADDR;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic [3:0] HPROT;
  logic HWRITE;
  logic [31:0] HWDATA;
  logic HREADY;
  logic HREADYOUT;
  logic [31:0] HRDATA;
  logic HRESP;
  modport slave(
    input HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
  modport master(
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    input HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahblite_vga_wbuf_sync_fifo.sv
// sync_fifo: synchronous FIFO with wrap-bit pointers and flush
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0] level,
  output logic full,
  output logic empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty & ~flush;
  assign level = wr_ptr - rd_ptr;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= flush ? wr_ptr : rd_ptr + (AW+1)'(do_pop);
    end
  always_ff @(posedge HCLK)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/ahblite_vga_wbuf.sv
// ahblite_vga_wbuf: AHB-Lite slave buffering character-cell writes toward a VGA engine
module ahblite_vga_wbuf
  import ahblite_vga_wbuf_pkg::*;
#(
  parameter int H_BITS = 5,
  parameter int V_BITS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic HCLK,
  input  logic HRESETn,
  ahblite_vga_wbuf_if.slave ahb,
  output logic vga_valid,
  input  logic vga_ready,
  output logic [H_BITS-1:0] vga_addr_h,
  output logic [V_BITS-1:0] vga_addr_v,
  output logic [31:0] vga_ctrl
);
  localparam int W = V_BITS + H_BITS + 32;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  dphase_t dp;
  logic en, is_reg, cell_wr, ctrl_wr, push, pop, flush, full, empty, unused_ok;
  logic [LW-1:0] level;
  logic [W-1:0] head;
  logic [31:0] status_word;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) dp <= '0;
    else if (ahb.HREADY) dp <= '{valid: ahb.HSEL & ahb.HTRANS[1], write: ahb.HWRITE, addr: ahb.HADDR[15:0]};
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) en <= 1'b1;
    else if (ctrl_wr) en <= ahb.HWDATA[CTRL_EN_BIT];
  assign is_reg = dp.addr[REG_SEL_BIT];
  assign cell_wr = dp.valid & dp.write & ~is_reg;
  assign ctrl_wr = dp.valid & dp.write & is_reg & reg_hit(dp.addr, CTRL_OFS);
  assign push = cell_wr & ~full;
  assign flush = ctrl_wr & ahb.HWDATA[CTRL_FLUSH_BIT];
  assign pop = vga_valid & vga_ready;
  assign vga_valid = en & ~empty;
  assign {vga_addr_v, vga_addr_h, vga_ctrl} = empty ? '0 : head;
  assign ahb.HREADYOUT = ~(cell_wr & full);
  assign ahb.HRESP = 1'b0;
  always_comb begin
    status_word = '0;
    status_word[STATUS_LEVEL_W-1:0] = STATUS_LEVEL_W'(level);
    status_word[STATUS_EMPTY_BIT] = empty;
    status_word[STATUS_FULL_BIT] = full;
    status_word[STATUS_EN_BIT] = en;
  end
  assign ahb.HRDATA = !(dp.valid & ~dp.write & is_reg) ? '0 :
                      reg_hit(dp.addr, STATUS_OFS) ? status_word :
                      reg_hit(dp.addr, CTRL_OFS) ? 32'(en) << CTRL_EN_BIT : '0;
  assign unused_ok = ^{ahb.HSIZE, ahb.HPROT, ahb.HADDR[31:16], ahb.HTRANS[0], dp.addr[1:0]};
  sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din({dp.addr[H_BITS+V_BITS+1:2], ahb.HWDATA}),
    .dout(head),
    .level(level),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ahblite_vga_wbuf.sv
// tb_ahblite_vga_wbuf: randomized scoreboard bench for the VGA write buffer
module tb_ahblite_vga_wbuf;
  localparam int H = 5, V = 4, D = 4;
  logic HCLK = 0;
  logic HRESETn = 0;
  logic vga_valid, vga_ready;
  logic [H-1:0] vga_addr_h;
  logic [V-1:0] vga_addr_v;
  logic [31:0] vga_ctrl;
  logic [40:0] ref_q[$];
  logic [40:0] mon_pay;
  bit op_w[32];
  logic [31:0] op_a[32], op_d[32], op_r[32];
  int tests = 0, fails = 0;
  bit abort = 0, rand_on = 0;
  logic en_m = 1'b1;
  logic [31:0] r;
  ahblite_vga_wbuf_if bus();
  assign bus.HREADY = bus.HREADYOUT;
  ahblite_vga_wbuf #(.H_BITS(H), .V_BITS(V), .FIFO_DEPTH(D)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus),
    .vga_valid(vga_valid), .vga_ready(vga_ready),
    .vga_addr_h(vga_addr_h), .vga_addr_v(vga_addr_v), .vga_ctrl(vga_ctrl)
  );
  always #5 HCLK = ~HCLK;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask
  function automatic logic [40:0] ent(input logic [31:0] a, input logic [31:0] d);
    return {V'(a >> (H + 2)), H'(a >> 2), d};
  endfunction
  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(ref_q.size());
    s[16] = ref_q.size() == 0;
    s[17] = ref_q.size() == D;
    s[18] = en_m;
    return s;
  endfunction
  task automatic complete(input int k);
    if (op_w[k] && !op_a[k][15]) ref_q.push_back(ent(op_a[k], op_d[k]));
    else if (op_w[k] && (op_a[k][15:0] & 16'hFFFC) == 16'h8004) begin
      en_m = op_d[k][0];
      if (op_d[k][1]) ref_q.delete();
    end
  endtask
  task automatic run(input int n);
    int wc;
    logic rdy;
    for (int i = 0; i <= n; i++) begin
      bus.HSEL = i < n;
      bus.HTRANS = (i < n) ? 2'b10 : 2'b00;
      bus.HWRITE = (i < n) ? op_w[i] : 1'b0;
      bus.HADDR = (i < n) ? op_a[i] : 32'h0;
      bus.HSIZE = 3'b010;
      bus.HPROT = 4'b0011;
      bus.HWDATA = (i > 0) ? op_d[i-1] : 32'h0;
      wc = 0;
      do begin
        @(negedge HCLK);
        rdy = bus.HREADYOUT;
        if (i > 0) op_r[i-1] = bus.HRDATA;
        @(posedge HCLK);
        #1;
        if (!rdy && ++wc > 200) begin
          tests++;
          fails++;
          $display("FAIL stall_timeout: HREADYOUT stuck at 0, required 1 within 200 cycles");
          rdy = 1;
        end
      end while (!rdy);
      if (i > 0 && !abort) complete(i - 1);
    end
  endtask
  task automatic set_op(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
    op_w[k] = w;
    op_a[k] = a;
    op_d[k] = d;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    set_op(0, 1, a, d);
    run(1);
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    set_op(0, 0, a, 0);
    run(1);
    d = op_r[0];
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask
  task automatic cell_writes(input int n);
    for (int k = 0; k < n; k++) set_op(k, 1, $urandom & 32'hFFFF_7FFF, $urandom);
    run(n);
  endtask
  always @(negedge HCLK) begin
    mon_pay = {vga_addr_v, vga_addr_h, vga_ctrl};
    chk("vga_valid", vga_valid, en_m && ref_q.size() > 0);
    chk("hresp", bus.HRESP, 0);
    if (ref_q.size() == 0) chk("idle_payload", mon_pay, 0);
    if (vga_valid && vga_ready) begin
      if (ref_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got %h required no entry", mon_pay);
      end else begin
        chk("pop_order", mon_pay, ref_q[0]);
        void'(ref_q.pop_front());
      end
    end
  end
  initial begin
    vga_ready = 0;
    bus.HSEL = 0; bus.HTRANS = 0; bus.HADDR = 0; bus.HWRITE = 0;
    bus.HWDATA = 0; bus.HSIZE = 0; bus.HPROT = 0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hreadyout", bus.HREADYOUT, 1);
    chk("rst_hrdata", bus.HRDATA, 0);
    chk("rst_valid", vga_valid, 0);
    @(posedge HCLK);
    #1 HRESETn = 1;
    vga_ready = 1;
    wr(32'h0104, 32'h0000_00AB);
    chk("t1_valid", vga_valid, 1);
    chk("t1_h", vga_addr_h, 1);
    chk("t1_v", vga_addr_v, 2);
    chk("t1_ctrl", vga_ctrl, 32'hAB);
    cycles(1);
    chk("t1_popped", vga_valid, 0);
    vga_ready = 0;
    for (int k = 0; k < 5; k++) set_op(k, 1, 32'h40 + 4 * k, $urandom);
    fork
      run(5);
      begin
        repeat (5) @(negedge HCLK);
        repeat (4) begin
          @(negedge HCLK);
          chk("t2_stall", bus.HREADYOUT, 0);
        end
        @(posedge HCLK);
        #1 vga_ready = 1;
        @(posedge HCLK);
        #1 vga_ready = 0;
      end
    join
    rd(32'h8000, r);
    chk("t2_status", r, 32'h0006_0004);
    vga_ready = 1;
    cycles(6);
    wr(32'h8004, 32'h0);
    cell_writes(2);
    cycles(3);
    chk("t3_blocked", vga_valid, 0);
    rd(32'h8000, r);
    chk("t3_status", r, 32'h0000_0002);
    wr(32'h8004, 32'h1);
    cycles(4);
    rd(32'h8000, r);
    chk("t3_drained", r, 32'h0005_0000);
    vga_ready = 0;
    cell_writes(3);
    vga_ready = 1;
    wr(32'h8004, 32'h3);
    chk("t4_valid", vga_valid, 0);
    set_op(0, 0, 32'h8000, 0);
    set_op(1, 0, 32'h8004, 0);
    run(2);
    chk("t4_status", op_r[0], 32'h0005_0000);
    chk("t4_ctrl", op_r[1], 32'h1);
    set_op(0, 1, 32'h8008, 32'hFFFF_FFFF);
    set_op(1, 0, 32'h8008, 0);
    set_op(2, 1, 32'h8000, 32'h0);
    set_op(3, 0, 32'h8004, 0);
    run(4);
    chk("unmapped_rd", op_r[1], 0);
    chk("ctrl_unchanged", op_r[3], 32'h1);
    vga_ready = 0;
    cell_writes(2);
    for (int k = 0; k < 12; k++) set_op(k, 1, $urandom & 32'h0000_7FFF, $urandom);
    fork
      run(12);
      begin
        @(posedge HCLK);
        #1 vga_ready = 1;
      end
    join
    vga_ready = 0;
    rd(32'h8000, r);
    chk("t6_level2", r, 32'h0004_0002);
    vga_ready = 1;
    cycles(4);
    vga_ready = 0;
    cell_writes(4);
    rd(32'h8000, r);
    chk("t5_full", r, 32'h0006_0004);
    set_op(0, 1, 32'h0200, 32'hDEAD_BEEF);
    fork
      run(1);
      begin
        repeat (4) @(negedge HCLK);
        chk("t5_stall", bus.HREADYOUT, 0);
        #2 HRESETn = 0;
        abort = 1;
        ref_q.delete();
        en_m = 1;
        #1;
        chk("t5_rst_ready", bus.HREADYOUT, 1);
        chk("t5_rst_valid", vga_valid, 0);
        chk("t5_rst_hrdata", bus.HRDATA, 0);
        @(posedge HCLK);
        #1 HRESETn = 1;
      end
    join
    abort = 0;
    vga_ready = 1;
    cycles(6);
    rd(32'h8000, r);
    chk("t5_status", r, 32'h0005_0000);
    rand_on = 1;
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          for (int k = 0; k < 16; k++)
            set_op(k, $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_7FFF, $urandom);
          run(16);
          for (int k = 0; k < 16; k++)
            if (!op_w[k]) chk("cell_read", op_r[k], 0);
        end
        rand_on = 0;
      end
      while (rand_on) begin
        @(posedge HCLK);
        #1 vga_ready = 1'($urandom_range(0, 1));
      end
    join
    vga_ready = 1;
    cycles(10);
    rd(32'h8000, r);
    chk("rand_status", r, exp_status());
    chk("rand_empty", r, 32'h0005_0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ahblite_vga_wbuf.md
AHBLITE_VGA_WBUF -- requirements
Module: ahblite_vga_wbuf

Interface
REQ-001 The block SHALL have parameter H_BITS, default 5, meaning the width of the character-column address.
REQ-002 The block SHALL have parameter V_BITS, default 4, meaning the width of the character-row address; H_BITS+V_BITS+2 <= 15.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning write-buffer entries (power of 2, 2..256).
REQ-004 The block SHALL be clocked by HCLK, with reset HRESETn, asynchronous, active-low.
REQ-005 The block SHALL have the following AHB-Lite slave inputs:
- HSEL, in, 1
- HADDR, in, 32
- HTRANS, in, 2
- HSIZE, in, 3
- HPROT, in, 4
- HWRITE, in, 1
- HWDATA, in, 32
- HREADY, in, 1
REQ-006 The block SHALL have the following AHB-Lite slave outputs:
- HREADYOUT, out, 1
- HRDATA, out, 32
- HRESP, out, 1, tied 0
REQ-007 The block SHALL have the following VGA-side ports:
- vga_valid, out, 1
- vga_ready, in, 1
- vga_addr_h, out, H_BITS
- vga_addr_v, out, V_BITS
- vga_ctrl, out, 32: cell data

Function
REQ-008 Address phase accepted when HSEL & HTRANS[1] & HREADY; the block SHALL register HADDR[15:0] and HWRITE for the following data phase.
REQ-009 Cell region HADDR[15]=0: the block SHALL map h = HADDR[H_BITS+1:2] and v = HADDR[H_BITS+V_BITS+1:H_BITS+2]; other bits are ignored.
REQ-010 Cell write data phase, FIFO not full: HREADYOUT=1, and the block SHALL push {v,h,HWDATA} on that edge.
REQ-011 Cell write data phase, FIFO full: the block SHALL drive HREADYOUT=0, holding HWDATA un-pushed until a non-full cycle, then push with HREADYOUT=1; HREADYOUT SHALL depend only on registered FIFO state, never combinationally on vga_ready.
REQ-012 Cell reads SHALL complete in zero wait states with HRDATA=0.
REQ-013 The block SHALL provide STATUS at 0x8000 (RO):
- [8:0] level
- [16] empty
- [17] full
- [18] EN
- other bits 0
REQ-014 The block SHALL provide CTRL at 0x8004 (RW):
- [0] EN, reset 1
- [1] FLUSH, write-1 self-clearing, reads 0
REQ-015 Other register-region addresses SHALL read 0 and ignore writes.
REQ-016 Register accesses SHALL complete in zero wait states; HRDATA SHALL be valid during the data phase; writes take effect on the data-phase end edge.
REQ-017 vga_valid SHALL equal EN & !empty; vga_addr_h, vga_addr_v and vga_ctrl SHALL show the FIFO head, and SHALL be 0 when empty.
REQ-018 The block SHALL pop on a rising edge with vga_valid & vga_ready; vga_valid held with stable payload until popped.
REQ-019 Simultaneous push and pop SHALL leave the level unchanged, with order preserved (FIFO).
REQ-020 FLUSH SHALL empty the FIFO on the CTRL write edge; a coincident pop is discarded, with no double-count.
REQ-021 EN=0 SHALL block pops only; pushes continue and stall when full.
REQ-022 HSIZE and HPROT SHALL be ignored; all accesses are treated as word.
REQ-023 Level arithmetic SHALL use pointers one bit wider than log2(FIFO_DEPTH); full = level==FIFO_DEPTH; pointers wrap modulo 2*FIFO_DEPTH.

Reset
REQ-024 On HRESETn low, the block SHALL asynchronously reach: FIFO empty, pointers 0, EN=1, data-phase registers cleared.
REQ-025 During reset, the block SHALL drive HREADYOUT=1, vga_valid=0, payload outputs 0 and HRDATA=0.
REQ-026 Reset mid-stall SHALL abandon the pending write with no push.

Structure
REQ-027 Register offsets (0x8000, 0x8004), STATUS/CTRL bit positions and the cell/register region select bit SHALL be constants in the shared SoC bus package.
REQ-028 The FIFO SHALL be a sub-module sync_fifo (params WIDTH, DEPTH; ports push, pop, flush, din, dout, level, full, empty), usable elsewhere.

Verification
REQ-029 The bench SHALL cover: write 0x0000_00AB to 0x0104, vga_ready=1 -> next cycle vga_valid=1, h=1, v=2, vga_ctrl=0xAB; popped one cycle later.
REQ-030 The bench SHALL cover: vga_ready=0, 5 back-to-back cell writes, DEPTH=4 -> the 5th data phase has HREADYOUT=0 until vga_ready pulses once; STATUS level=4, full=1 afterwards.
REQ-031 The bench SHALL cover: CTRL write 0x0 (EN=0), 2 writes, vga_ready=1 -> vga_valid=0, level=2; CTRL write 0x1 -> both entries are popped in order.
REQ-032 The bench SHALL cover: FIFO 3 entries, CTRL write 0x3 with vga_ready=1 -> level=0, empty=1, vga_valid=0 the next cycle, and a CTRL read returns 0x1.
REQ-033 The bench SHALL cover: HRESETn asserted while stalled full -> HREADYOUT=1, level=0, and the stalled data is never emitted.
REQ-034 The bench SHALL cover: push and pop in the same cycle at level 2 -> level stays 2, with output order matching write order across pointer wrap (>=10 writes).
